// File: rtl/responder_pkg.sv
// Shared state encodings, player count and winner helpers for the quiz responder front end.
package responder_pkg;

    localparam int         PLAYERS     = 4;
    localparam logic [2:0] WINNER_NONE = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_ANSWERED = 3'd2,
        ST_JUDGED   = 3'd3,
        ST_TIMEOUT  = 3'd4,
        ST_FOUL     = 3'd5
    } state_t;

    // Lowest-index pressed player wins a tie; returns 1..4, or WINNER_NONE.
    function automatic logic [2:0] first_player(input logic [PLAYERS-1:0] press);
        logic [2:0] id;
        id = WINNER_NONE;
        for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (press[i]) id = 3'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Purpose: 2-flop synchroniser plus rising-edge pulse for one raw button.
// Latency: pin edge -> rise pulse valid after the 2nd clk; the consumer registers it on the 3rd.
// Backpressure: none; a pulse is one cycle wide and never held.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh <= 3'b000;
        else        sh <= {sh[1:0], din};
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/responder_arbiter.sv
// Purpose: 4-player quiz arbiter (button sync, countdown, first-press latch, host judging, scores).
// Latency: raw pin edge -> registered output change 3 clk later; no handshakes.
// Backpressure: none; events outside their state are dropped. FOUL_DETECT_EN enables IDLE fouls.
module responder_arbiter
    import responder_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ANSWER_TIME = 30,
    parameter int SCORE_W     = 4,
    parameter int SCORE_INIT  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   player1,
    input  logic                   player2,
    input  logic                   player3,
    input  logic                   player4,
    input  logic                   starttimer,
    input  logic                   yes,
    input  logic                   no,
    input  logic                   nextset,
    output logic [2:0]             winner,
    output logic [5:0]             countdown,
    output logic [4*SCORE_W-1:0]   scores,
    output logic [2:0]             state,
    output logic                   alarm
);

    localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Reset asserts asynchronously but releases two clocks after rst rises.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    logic [7:0] raw;
    logic [7:0] rise;
    assign raw = {nextset, no, yes, starttimer, player4, player3, player2, player1};

    for (genvar g = 0; g < 8; g++) begin : g_sync
        btn_sync_edge u_sync (
            .clk   (clk),
            .rst_n (rst_n_int),
            .din   (raw[g]),
            .rise  (rise[g])
        );
    end

    logic [PLAYERS-1:0] p_rise;
    logic               start_rise, yes_rise, no_rise, next_rise;
    assign p_rise     = rise[3:0];
    assign start_rise = rise[4];
    assign yes_rise   = rise[5];
    assign no_rise    = rise[6];
    assign next_rise  = rise[7];

    state_t             state_q;
    logic [2:0]         winner_q;
    logic [5:0]         cd_q;
    logic [TW-1:0]      tick_q;
    logic               alarm_q;
    logic [SCORE_W-1:0] score_q [PLAYERS];

    logic [2:0] p_id;
    logic [1:0] w_idx;
    assign p_id  = first_player(p_rise);
    assign w_idx = 2'(winner_q - 3'd1);
`ifdef FOUL_DETECT_EN
    logic [1:0] p_idx;
    assign p_idx = 2'(p_id - 3'd1);
`endif

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= ST_IDLE;
            winner_q <= WINNER_NONE;
            cd_q     <= 6'd0;
            tick_q   <= '0;
            alarm_q  <= 1'b0;
            for (int i = 0; i < PLAYERS; i++) score_q[i] <= SCORE_W'(SCORE_INIT);
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef FOUL_DETECT_EN
                    if (|p_rise) begin
                        state_q  <= ST_FOUL;
                        winner_q <= p_id;
                        alarm_q  <= 1'b1;
                        if (score_q[p_idx] != '0) score_q[p_idx] <= score_q[p_idx] - SCORE_W'(1);
                    end else
`endif
                    if (start_rise) begin
                        state_q <= ST_ARMED;
                        cd_q    <= 6'(ANSWER_TIME);
                        tick_q  <= '0;
                    end
                end
                ST_ARMED: begin
                    // A press beats a countdown expiring in the same cycle.
                    if (next_rise) begin
                        state_q  <= ST_IDLE;
                        winner_q <= WINNER_NONE;
                        cd_q     <= 6'd0;
                    end else if (|p_rise) begin
                        state_q  <= ST_ANSWERED;
                        winner_q <= p_id;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        cd_q   <= cd_q - 6'd1;
                        if (cd_q == 6'd1) begin
                            state_q <= ST_TIMEOUT;
                            alarm_q <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                ST_ANSWERED: begin
                    if (next_rise) begin
                        state_q  <= ST_IDLE;
                        winner_q <= WINNER_NONE;
                        cd_q     <= 6'd0;
                    end else if (yes_rise ^ no_rise) begin
                        state_q <= ST_JUDGED;
                        if (yes_rise) begin
                            if (score_q[w_idx] != SCORE_MAX) score_q[w_idx] <= score_q[w_idx] + SCORE_W'(1);
                        end else begin
                            if (score_q[w_idx] != '0) score_q[w_idx] <= score_q[w_idx] - SCORE_W'(1);
                        end
                    end
                end
                default: begin
                    if (next_rise) begin
                        state_q  <= ST_IDLE;
                        winner_q <= WINNER_NONE;
                        cd_q     <= 6'd0;
                        alarm_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_scores
        assign scores[p*SCORE_W +: SCORE_W] = score_q[p];
    end

    assign winner    = winner_q;
    assign countdown = cd_q;
    assign state     = state_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_responder_arbiter.sv
// Bench for responder_arbiter: event-level reference model checked every cycle, plus literal expectations.
module tb_responder_arbiter;

    localparam int TICK_DIV    = 4;
    localparam int ANSWER_TIME = 5;
    localparam int SCORE_W     = 4;
    localparam int SCORE_INIT  = 5;
    localparam int SMAX        = (1 << SCORE_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  btn = 8'h00;   // 0..3 players, 4 start, 5 yes, 6 no, 7 nextset
    logic [2:0]  winner;
    logic [5:0]  countdown;
    logic [15:0] scores;
    logic [2:0]  state;
    logic        alarm;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 0;

    responder_arbiter #(
        .TICK_DIV(TICK_DIV), .ANSWER_TIME(ANSWER_TIME), .SCORE_W(SCORE_W), .SCORE_INIT(SCORE_INIT)
    ) dut (
        .clk(clk), .rst(rst),
        .player1(btn[0]), .player2(btn[1]), .player3(btn[2]), .player4(btn[3]),
        .starttimer(btn[4]), .yes(btn[5]), .no(btn[6]), .nextset(btn[7]),
        .winner(winner), .countdown(countdown), .scores(scores), .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Reference model: states as plain integers, events derived from pin history.
    int m_state, m_winner, m_cd, m_tick, m_alarm, run;
    int m_score [4];
    logic [7:0] h1, h2, h3;

    task automatic m_reset();
        m_state = 0; m_winner = 0; m_cd = 0; m_tick = 0; m_alarm = 0;
        for (int i = 0; i < 4; i++) m_score[i] = SCORE_INIT;
    endtask

    task automatic m_idle();
        m_state = 0; m_winner = 0; m_cd = 0; m_alarm = 0;
    endtask

    task automatic model_step(input logic [7:0] ev);
        int pl;
        pl = 0;
        for (int i = 3; i >= 0; i--) if (ev[i]) pl = i + 1;
        case (m_state)
            0: begin
`ifdef FOUL_DETECT_EN
                if (pl != 0) begin
                    m_state = 5; m_winner = pl; m_alarm = 1;
                    if (m_score[pl-1] > 0) m_score[pl-1] = m_score[pl-1] - 1;
                end else
`endif
                if (ev[4]) begin m_state = 1; m_cd = ANSWER_TIME; m_tick = 0; end
            end
            1: begin
                if (ev[7]) m_idle();
                else if (pl != 0) begin m_state = 2; m_winner = pl; end
                else begin
                    m_tick = m_tick + 1;
                    if (m_tick == TICK_DIV) begin
                        m_tick = 0;
                        m_cd = m_cd - 1;
                        if (m_cd == 0) begin m_state = 4; m_alarm = 1; end
                    end
                end
            end
            2: begin
                if (ev[7]) m_idle();
                else if (ev[5] != ev[6]) begin
                    if (ev[5]) m_score[m_winner-1] = (m_score[m_winner-1] < SMAX) ? m_score[m_winner-1] + 1 : SMAX;
                    else       m_score[m_winner-1] = (m_score[m_winner-1] > 0) ? m_score[m_winner-1] - 1 : 0;
                    m_state = 3;
                end
            end
            default: if (ev[7]) m_idle();
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset(); run = 0; h1 = 0; h2 = 0; h3 = 0;
        end else begin
            if (run >= 2) begin
                model_step(h2 & ~h3);
                h3 = h2; h2 = h1; h1 = btn;
            end
            if (run < 2) run = run + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] exp_sc;
            exp_sc = {4'(m_score[3]), 4'(m_score[2]), 4'(m_score[1]), 4'(m_score[0])};
            n_total++;
            if (state === 3'(m_state) && winner === 3'(m_winner) && countdown === 6'(m_cd) &&
                scores === exp_sc && alarm === 1'(m_alarm)) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_cmp t=%0t act st=%0d w=%0d cd=%0d sc=%h al=%0d req st=%0d w=%0d cd=%0d sc=%h al=%0d",
                         $time, state, winner, countdown, scores, alarm,
                         m_state, m_winner, m_cd, exp_sc, m_alarm);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s act=%0d req=%0d", name, act, req);
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int b);
        btn[b] = 1'b1;
        clk_n(2);
        btn[b] = 1'b0;
    endtask

    initial begin
        // 1. reset
        #2 rst = 1'b0;
        cmp_en = 1;
        clk_n(3);
        rst = 1'b1;
        clk_n(4);
        chk("rst_state", int'(state), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_countdown", int'(countdown), 0);
        chk("rst_scores", int'(scores), 16'h5555);
        chk("rst_alarm", int'(alarm), 0);

        // 2. start, player1 ten clocks later, yes
        pulse(4);
        clk_n(8);
        pulse(0);
        clk_n(5);
        chk("ans_state", int'(state), 2);
        chk("ans_winner", int'(winner), 1);
        chk("ans_frozen_cd", int'(countdown), 3);
        clk_n(4);
        chk("ans_still_cd", int'(countdown), 3);
        pulse(5);
        clk_n(4);
        chk("yes_score1", int'(scores[3:0]), 6);
        chk("yes_state", int'(state), 3);
        pulse(7);
        clk_n(4);

        // 3. timeout path
        pulse(4);
        clk_n(5);
        chk("tick_cd4", int'(countdown), 4);
        clk_n(25);
        chk("to_state", int'(state), 4);
        chk("to_alarm", int'(alarm), 1);
        chk("to_cd", int'(countdown), 0);
        pulse(7);
        clk_n(4);
        chk("to_next_state", int'(state), 0);
        chk("to_next_alarm", int'(alarm), 0);

        // 4. simultaneous press, late press, abort
        pulse(4);
        clk_n(4);
        btn[2] = 1'b1; btn[1] = 1'b1;
        clk_n(2);
        btn[2] = 1'b0; btn[1] = 1'b0;
        clk_n(2);
        pulse(3);
        clk_n(4);
        chk("tie_winner", int'(winner), 2);
        chk("tie_state", int'(state), 2);
        pulse(7);
        clk_n(4);
        chk("abort_state", int'(state), 0);
        chk("abort_scores", int'(scores), 16'h5556);

        // 5. saturation
        for (int r = 0; r < 11; r++) begin
            pulse(4); clk_n(4); pulse(3); clk_n(3); pulse(5); clk_n(3); pulse(7); clk_n(3);
        end
        chk("sat_score4", int'(scores[15:12]), 15);
        for (int r = 0; r < 7; r++) begin
            pulse(4); clk_n(4); pulse(0); clk_n(3); pulse(6); clk_n(3); pulse(7); clk_n(3);
            if (r == 5) chk("floor_score1_6th", int'(scores[3:0]), 0);
        end
        chk("floor_scores", int'(scores), 16'hF550);

        // 6. player press in IDLE
        pulse(1);
        clk_n(4);
`ifdef FOUL_DETECT_EN
        chk("foul_state", int'(state), 5);
        chk("foul_winner", int'(winner), 2);
        chk("foul_score2", int'(scores[7:4]), 4);
        chk("foul_alarm", int'(alarm), 1);
        pulse(7);
        clk_n(4);
        chk("foul_clear_alarm", int'(alarm), 0);
`else
        chk("idle_press_state", int'(state), 0);
        chk("idle_press_winner", int'(winner), 0);
        chk("idle_press_scores", int'(scores), 16'hF550);
`endif

        // reset while ANSWERED
        pulse(4);
        clk_n(4);
        pulse(0);
        clk_n(4);
        chk("pre_rst_state", int'(state), 2);
        rst = 1'b0;
        #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_winner", int'(winner), 0);
        chk("midrst_scores", int'(scores), 16'h5555);
        chk("midrst_cd", int'(countdown), 0);
        chk("midrst_alarm", int'(alarm), 0);
        clk_n(2);
        rst = 1'b1;
        clk_n(5);
        chk("post_rst_state", int'(state), 0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
